// File: rtl/gpu_pkg.sv
// Shared constants and types for the 2D primitive pipeline: screen geometry,
// the positions field layout and the circle rasteriser state encoding.
package gpu_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam int unsigned PosW     = 38;
  localparam int unsigned PosCxLsb = 28;
  localparam int unsigned PosCyLsb = 19;
  localparam int unsigned PosRLsb  = 9;
  localparam int unsigned CxW      = 10;
  localparam int unsigned CyW      = 9;
  localparam int unsigned RW       = 10;

  localparam int unsigned AddrW  = 19;
  localparam int unsigned CoordW = 12;
  localparam int unsigned DecW   = 14;

  typedef logic signed [CoordW-1:0] coord_t;
  typedef logic signed [DecW-1:0]   dec_t;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StPlot,
    StUpdate,
    StDone
  } state_e;

endpackage

// File: rtl/bresen_circle_if.sv
// Command/result bundle between the primitive dispatcher and the circle rasteriser.
interface bresen_circle_if;
  import gpu_pkg::*;

  logic [PosW-1:0]  positions;
  logic             primSelect;
  logic             stop;
  logic [AddrW-1:0] address;
  logic             circleDone;

  modport master (
    output positions, primSelect, stop,
    input  address, circleDone
  );

  modport slave (
    input  positions, primSelect, stop,
    output address, circleDone
  );

endinterface

// File: rtl/circle_addr_calc.sv
// Clips a signed screen coordinate and converts it to a linear framebuffer address.
module circle_addr_calc
  import gpu_pkg::*;
(
  input  coord_t            px_i,
  input  coord_t            py_i,
  output logic              on_screen_o,
  output logic [AddrW-1:0]  addr_o
);

  always_comb begin
    on_screen_o = (px_i >= coord_t'(0)) && (px_i < coord_t'(SCREEN_W)) &&
                  (py_i >= coord_t'(0)) && (py_i < coord_t'(SCREEN_H));
    // Only meaningful when on_screen_o is set; low bits suffice for in-range points.
    addr_o = AddrW'(py_i[8:0]) * AddrW'(SCREEN_W) + AddrW'(px_i[9:0]);
  end

endmodule

// File: rtl/bresen_circle.sv
// Midpoint circle rasteriser: walks one octant and emits the eight mirrored
// points one per clock as framebuffer addresses, skipping off-screen ones.
module bresen_circle
  import gpu_pkg::*;
(
  input  logic            clk,
  input  logic            n_rst,
  bresen_circle_if.slave  bus
);

  state_e           state_q, state_d;
  coord_t           cx_q, cx_d, cy_q, cy_d, r_q, r_d;
  coord_t           x_q, x_d, y_q, y_d;
  dec_t             d_q, d_d;
  logic [2:0]       oct_q, oct_d;
  logic [AddrW-1:0] addr_q, addr_d;

  coord_t           px, py, x_inc;
  logic             on_screen;
  logic [AddrW-1:0] calc_addr;
  logic             unused_pos;

  assign unused_pos = ^bus.positions[PosRLsb-1:0];

  circle_addr_calc u_addr_calc (
    .px_i        (px),
    .py_i        (py),
    .on_screen_o (on_screen),
    .addr_o      (calc_addr)
  );

  // Octant mirror selection.
  always_comb begin
    px = cx_q;
    py = cy_q;
    unique case (oct_q)
      3'd0: begin px = cx_q + x_q; py = cy_q + y_q; end
      3'd1: begin px = cx_q - x_q; py = cy_q + y_q; end
      3'd2: begin px = cx_q + x_q; py = cy_q - y_q; end
      3'd3: begin px = cx_q - x_q; py = cy_q - y_q; end
      3'd4: begin px = cx_q + y_q; py = cy_q + x_q; end
      3'd5: begin px = cx_q - y_q; py = cy_q + x_q; end
      3'd6: begin px = cx_q + y_q; py = cy_q - x_q; end
      3'd7: begin px = cx_q - y_q; py = cy_q - x_q; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    r_d     = r_q;
    x_d     = x_q;
    y_d     = y_q;
    d_d     = d_q;
    oct_d   = oct_q;
    addr_d  = addr_q;
    x_inc   = x_q + coord_t'(1);

    if (!bus.stop) begin
      unique case (state_q)
        StIdle: begin
          if (bus.primSelect) begin
            cx_d    = coord_t'(bus.positions[PosCxLsb +: CxW]);
            cy_d    = coord_t'(bus.positions[PosCyLsb +: CyW]);
            r_d     = coord_t'(bus.positions[PosRLsb +: RW]);
            state_d = StInit;
          end
        end
        StInit: begin
          x_d     = coord_t'(0);
          y_d     = r_q;
          d_d     = dec_t'(3) - (dec_t'(r_q) <<< 1);
          oct_d   = 3'd0;
          state_d = StPlot;
        end
        StPlot: begin
          if (on_screen) begin
            addr_d = calc_addr;
          end
          oct_d = oct_q + 3'd1;
          if (oct_q == 3'd7) begin
            state_d = StUpdate;
          end
        end
        StUpdate: begin
          if (d_q < dec_t'(0)) begin
            d_d = d_q + (dec_t'(x_q) <<< 2) + dec_t'(6);
          end else begin
            d_d = d_q + (dec_t'(x_q - y_q) <<< 2) + dec_t'(10);
            y_d = y_q - coord_t'(1);
          end
          x_d   = x_inc;
          oct_d = 3'd0;
          state_d = (x_inc > y_d) ? StDone : StPlot;
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      cx_q    <= '0;
      cy_q    <= '0;
      r_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      oct_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      r_q     <= r_d;
      x_q     <= x_d;
      y_q     <= y_d;
      d_q     <= d_d;
      oct_q   <= oct_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.address    = addr_q;
  assign bus.circleDone = (state_q == StDone);

endmodule

// File: tb/tb_bresen_circle.sv
// Bench for bresen_circle: an integer reference of the midpoint circle walk
// predicts the address/done trace for every clock; directed literals pin it.
module tb_bresen_circle;

  typedef struct {
    int addr;  // -1 means the address register holds
    bit done;
  } ent_t;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  bresen_circle_if bus ();

  bresen_circle dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  ent_t q[$];
  int   exp_addr;
  int   exp_done;
  int   errors;
  int   checks;
  int   done_seen;

  function automatic void push_ent(int a, bit dn);
    ent_t e;
    e.addr = a;
    e.done = dn;
    q.push_back(e);
  endfunction

  // Expected per-clock trace of one circle, starting at the accepting edge.
  function automatic void build(logic [37:0] p);
    int cx, cy, r, x, y, d;
    int px[8];
    int py[8];
    cx = int'(p[37:28]);
    cy = int'(p[27:19]);
    r  = int'(p[18:9]);
    push_ent(-1, 1'b0);  // setup clock
    push_ent(-1, 1'b0);  // first point being computed
    x = 0;
    y = r;
    d = 3 - 2 * r;
    for (int it = 0; it < 4000; it++) begin
      px[0] = cx + x; py[0] = cy + y;
      px[1] = cx - x; py[1] = cy + y;
      px[2] = cx + x; py[2] = cy - y;
      px[3] = cx - x; py[3] = cy - y;
      px[4] = cx + y; py[4] = cy + x;
      px[5] = cx - y; py[5] = cy + x;
      px[6] = cx + y; py[6] = cy - x;
      px[7] = cx - y; py[7] = cy - x;
      for (int k = 0; k < 8; k++) begin
        if (px[k] >= 0 && px[k] < 640 && py[k] >= 0 && py[k] < 480)
          push_ent(py[k] * 640 + px[k], 1'b0);
        else
          push_ent(-1, 1'b0);
      end
      if (d < 0) begin
        d = d + 4 * x + 6;
      end else begin
        d = d + 4 * (x - y) + 10;
        y = y - 1;
      end
      x = x + 1;
      if (x > y) begin
        push_ent(-1, 1'b1);
        push_ent(-1, 1'b0);
        break;
      end
      push_ent(-1, 1'b0);
    end
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample inputs at the edge, advance the model, compare 1 time unit later.
  task automatic tick();
    logic        s_stop, s_ps, s_rst;
    logic [37:0] s_pos;
    ent_t        e;
    @(posedge clk);
    s_stop = bus.stop;
    s_ps   = bus.primSelect;
    s_pos  = bus.positions;
    s_rst  = n_rst;
    #1;
    if (!s_rst || !n_rst) begin
      q.delete();
      exp_addr = 0;
      exp_done = 0;
    end else if (!s_stop) begin
      if (q.size() == 0 && s_ps) build(s_pos);
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.addr >= 0) exp_addr = e.addr;
        exp_done = int'(e.done);
      end
    end
    check("address", int'(bus.address), exp_addr);
    check("circleDone", int'(bus.circleDone), exp_done);
    if (bus.circleDone) done_seen++;
    checks++;
    if (int'(bus.address) >= 307200) begin
      errors++;
      $display("FAIL addr_range: got %0d, expected < 307200", bus.address);
    end
  endtask

  task automatic start(logic [37:0] p);
    bus.positions  = p;
    bus.primSelect = 1'b1;
    tick();
    bus.primSelect = 1'b0;
    bus.positions  = '1;  // ignored while busy
  endtask

  task automatic run_until_idle(int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", q.size(), 0);
  endtask

  // Start a small circle and pin the eight points plus the done pulse literally.
  task automatic run_literal(string name, logic [37:0] p, input int exp8[8]);
    int last;
    start(p);
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      check({name, "_pt"}, int'(bus.address), exp8[k]);
    end
    last = exp8[7];
    tick();
    check({name, "_done"}, int'(bus.circleDone), 1);
    check({name, "_done_addr"}, int'(bus.address), last);
    tick();
    check({name, "_done_drop"}, int'(bus.circleDone), 0);
  endtask

  initial begin
    int r0_exp[8];
    int r1_exp[8];
    int clip_exp[8];
    logic [37:0] p;
    int frozen;

    errors = 0;
    checks = 0;
    done_seen = 0;
    exp_addr = 0;
    exp_done = 0;
    r0_exp   = '{12810, 12810, 12810, 12810, 12810, 12810, 12810, 12810};
    r1_exp   = '{3845, 3845, 2565, 2565, 3206, 3204, 3206, 3204};
    clip_exp = '{640, 640, 640, 640, 1, 1, 1, 1};

    n_rst = 1'b0;
    bus.positions  = '0;
    bus.primSelect = 1'b0;
    bus.stop       = 1'b0;
    #3;
    check("reset_address", int'(bus.address), 0);
    check("reset_done", int'(bus.circleDone), 0);
    tick();
    tick();
    n_rst = 1'b1;
    repeat (3) tick();

    p = {10'd10, 9'd20, 10'd0, 9'd0};
    run_literal("r0", p, r0_exp);
    p = {10'd5, 9'd5, 10'd1, 9'd0};
    run_literal("r1", p, r1_exp);
    p = {10'd0, 9'd0, 10'd1, 9'd0};
    run_literal("clip", p, clip_exp);

    // Start request while frozen in idle must not be taken.
    bus.stop = 1'b1;
    bus.positions = {10'd5, 9'd5, 10'd1, 9'd0};
    bus.primSelect = 1'b1;
    tick();
    tick();
    bus.primSelect = 1'b0;
    bus.stop = 1'b0;
    repeat (3) tick();
    check("idle_stop_no_start", int'(bus.address), 1);

    // Large circle: freeze, busy start request, exactly one done pulse.
    done_seen = 0;
    start({10'd320, 9'd240, 10'd470, 9'd0});
    repeat (400) tick();
    bus.stop = 1'b1;
    tick();
    frozen = int'(bus.address);
    repeat (10) tick();
    check("stop_frozen", int'(bus.address), frozen);
    bus.stop = 1'b0;
    repeat (200) tick();
    bus.positions = {10'd5, 9'd5, 10'd1, 9'd0};
    bus.primSelect = 1'b1;
    tick();
    bus.primSelect = 1'b0;
    run_until_idle(6000);
    repeat (3) tick();
    check("done_pulses", done_seen, 1);

    // Reset in the middle of a draw, then a clean restart.
    start({10'd100, 9'd100, 10'd50, 9'd0});
    repeat (20) tick();
    n_rst = 1'b0;
    #1;
    check("midreset_address", int'(bus.address), 0);
    check("midreset_done", int'(bus.circleDone), 0);
    tick();
    tick();
    n_rst = 1'b1;
    repeat (2) tick();
    p = {10'd5, 9'd5, 10'd1, 9'd0};
    run_literal("restart", p, r1_exp);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
